// File: rtl/isqr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : isqr_pkg
// Brief   : Shared widths and FSM state type for the sequential squarer.
// Revision: 1.0 - initial release
// ============================================================================
package isqr_pkg;

  localparam int ISQR_W   = 11;
  localparam int ISQR_SQW = 2 * ISQR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } isqr_state_t;

endpackage
`default_nettype wire

// File: rtl/isqr_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : isqr_seq_if
// Brief   : Operand/result handshake bundle; x/ok exist with SQR_RANGE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
interface isqr_seq_if #(
  parameter int W = isqr_pkg::ISQR_W
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   r;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] sq;
`ifdef SQR_RANGE_CHECK_EN
  logic [2*W-1:0] x;
  logic           ok;

  modport master (
    output in_valid, r, x, out_ready,
    input  in_ready, out_valid, sq, ok
  );

  modport slave (
    input  in_valid, r, x, out_ready,
    output in_ready, out_valid, sq, ok
  );
`else
  modport master (
    output in_valid, r, out_ready,
    input  in_ready, out_valid, sq
  );

  modport slave (
    input  in_valid, r, out_ready,
    output in_ready, out_valid, sq
  );
`endif

endinterface
`default_nettype wire

// File: rtl/isqr_range_cmp.sv
`default_nettype none
// ============================================================================
// Module  : isqr_range_cmp
// Brief   : ok = sq <= x < sq + 2r + 1, i.e. r is the floor root of x.
//           Built only with SQR_RANGE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`ifdef SQR_RANGE_CHECK_EN
module isqr_range_cmp
  import isqr_pkg::*;
#(
  parameter int W = ISQR_W
) (
  input  logic [2*W-1:0] sq,
  input  logic [W-1:0]   r,
  input  logic [2*W-1:0] x,
  output logic           ok
);

  logic [2*W:0] w_sq;
  logic [2*W:0] w_x;
  logic [2*W:0] w_hi;

  assign w_sq = {1'b0, sq};
  assign w_x  = {1'b0, x};
  // {r,1} is 2r+1; the extra top bit keeps (2^W-1)^2 + 2^(W+1) - 1 exact
  assign w_hi = w_sq + {{W{1'b0}}, r, 1'b1};
  assign ok   = (w_sq <= w_x) && (w_x < w_hi);

endmodule
`endif
`default_nettype wire

// File: rtl/isqr_seq.sv
`default_nettype none
// ============================================================================
// Module  : isqr_seq
// Brief   : Shift-add squarer, one multiplier bit per clock, valid/ready on
//           both sides. Optional floor-root check under SQR_RANGE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module isqr_seq
  import isqr_pkg::*;
#(
  parameter int W = ISQR_W
) (
  input  logic       clk,
  input  logic       rst,
  isqr_seq_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  isqr_state_t    r_state;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_sq;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [2*W-1:0] w_sum;
`ifdef SQR_RANGE_CHECK_EN
  logic [W-1:0]   r_root;
  logic [2*W-1:0] r_x;
  logic           w_ok;
`endif

  assign w_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mplier    <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_sq        <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SQR_RANGE_CHECK_EN
      r_root      <= '0;
      r_x         <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mplier   <= bus.r;
            r_mcand    <= {{W{1'b0}}, bus.r};
            r_acc      <= '0;
            r_cnt      <= CW'(W - 1);
            r_in_ready <= 1'b0;
            r_state    <= CALC;
`ifdef SQR_RANGE_CHECK_EN
            r_root     <= bus.r;
            r_x        <= bus.x;
`endif
          end
        end
        CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          // No early exit on a zero multiplier: latency is always W edges
          if (r_cnt == '0) begin
            r_sq        <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sq        = r_sq;

`ifdef SQR_RANGE_CHECK_EN
  isqr_range_cmp #(
    .W (W)
  ) u_range_cmp (
    .sq (r_sq),
    .r  (r_root),
    .x  (r_x),
    .ok (w_ok)
  );

  assign bus.ok = r_out_valid & w_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isqr_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_isqr_seq
// Brief   : Scoreboard bench for isqr_seq; range-check cases need SQR_RANGE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_isqr_seq;
  import isqr_pkg::*;

  localparam int W = ISQR_W;

  typedef struct {
    longint sq;
    bit     ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  isqr_seq_if #(.W(W)) bus ();

  isqr_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t   expq[$];
  int     acc_cyc_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     last_acc = 0;
  bit     mon_en = 1'b0;
  bit     rnd_rdy = 1'b0;
  bit     rdy_force = 1'b1;
  bit     prev_v = 1'b0;
  bit     prev_r = 1'b0;
  longint prev_sq = 0;
  exp_t   e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact floor square root by real sqrt plus integer correction
  function automatic longint isqrt(input longint v);
    longint s;
    s = longint'($floor($sqrt(real'(v))));
    while (s * s > v) s--;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  // Single driver of out_ready: random or forced level, updated after each edge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  task automatic op(input longint rv, input longint xv, input bit keep);
    int  guard;
    exp_t ex;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.r        = rv[W-1:0];
`ifdef SQR_RANGE_CHECK_EN
    bus.x        = xv[2*W-1:0];
`endif
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      ex.sq = rv * rv;
      ex.ok = (isqrt(xv) == rv);
      expq.push_back(ex);
      acc_cyc_q.push_back(cyc + 1);
      last_acc = cyc + 1;
    end
    @(posedge clk);
    #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (expq.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each handshake
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.out_valid && !prev_v) begin
        if (acc_cyc_q.size() > 0) chk("latency", cyc - acc_cyc_q.pop_front(), W);
        else chk("unexpected_valid", 1, 0);
      end
      if (bus.out_valid) chk("in_ready_done", bus.in_ready, 0);
      else if (acc_cyc_q.size() > 0 && cyc >= acc_cyc_q[0]) chk("in_ready_calc", bus.in_ready, 0);
      if (prev_v && !prev_r) begin
        chk("valid_hold", bus.out_valid, 1);
        chk("sq_hold", bus.sq, prev_sq);
      end
`ifdef SQR_RANGE_CHECK_EN
      if (!bus.out_valid) chk("ok_idle", bus.ok, 0);
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("result_no_expect", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("sq", bus.sq, e.sq);
`ifdef SQR_RANGE_CHECK_EN
          chk("ok", bus.ok, e.ok);
`endif
        end
      end
      prev_v  = bus.out_valid;
      prev_r  = bus.out_ready;
      prev_sq = bus.sq;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    longint xr;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.r        = '0;
`ifdef SQR_RANGE_CHECK_EN
    bus.x        = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sq", bus.sq, 0);
`ifdef SQR_RANGE_CHECK_EN
    chk("rst_ok", bus.ok, 0);
`endif
    rst    = 1'b0;
    mon_en = 1'b1;

    // Zero root still takes the full W cycles
    op(0, 0, 0);
    drain();
    op(1448, 2096704, 0);
    op(2047, 4190209, 0);
    drain();

    // Back-pressure with a competing operand waiting
    rdy_force = 1'b0;
    op(37, 1369, 0);
    fork
      op(99, 9801, 0);
      begin
        a1 = 0;
        while (!bus.out_valid && a1 < 50) begin
          @(negedge clk);
          a1++;
        end
        repeat (6) begin
          @(negedge clk);
          chk("bp_valid", bus.out_valid, 1);
          chk("bp_sq", bus.sq, 1369);
          chk("bp_in_ready", bus.in_ready, 0);
        end
        rdy_force = 1'b1;
      end
    join
    drain();

    // Abort mid-CALC: async reset, no result may follow
    op(1000, 0, 0);
    repeat (4) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_sq", bus.sq, 0);
    expq.delete();
    acc_cyc_q.delete();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    op(3, 9, 0);
    drain();

    // Back-to-back with in_valid held high
    op(5, 25, 1);
    a1 = last_acc;
    op(6, 36, 0);
    chk("b2b_spacing", last_acc - a1, W + 2);
    drain();

    // Floor-root window edges around 1448^2
    op(1448, 2096703, 0);
    op(1448, 2099600, 0);
    op(1448, 2099601, 0);
    drain();

    // Exhaustive sweep under random back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < (1 << W); i++) begin
      if ($urandom_range(0, 1) != 0) xr = longint'($urandom_range(0, (1 << (2 * W)) - 1));
      else xr = longint'(i) * i + $urandom_range(0, 2 * i + 1);
      if (xr > (1 << (2 * W)) - 1) xr = (1 << (2 * W)) - 1;
      op(i, xr, 0);
    end
    drain();
    rnd_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/isqr_seq.md
Name: isqr_seq

Overview:
- Multi-cycle integer squarer: the inverse of the team's combinational integer square root.
- Accepts a root r and returns r*r using a shift-add datapath, one multiplier bit per clock.
- Sits next to the sqrt unit in the arithmetic cluster. Used to reconstruct squares for distance/score computations, and to cross-check sqrt results on the bench and in-system.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- W, 11, root width in bits. Result width is 2*W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  root operand presented
- in_ready  output  1  block can accept an operand
- r  input  W  root operand, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sq  output  2*W  r*r, unsigned, exact (no truncation)
- x  input  2*W  value to check against (present only with SQR_RANGE_CHECK_EN)
- ok  output  1  r == floor(sqrt(x)) (present only with SQR_RANGE_CHECK_EN)

Behaviour:
- Reset:
  - rst high asynchronously forces state IDLE.
  - Outputs: in_ready=1, out_valid=0, sq=0, ok=0.
  - Internal accumulator, shifted multiplicand, bit counter and operand registers all clear to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch r into the multiplier and multiplicand registers, and latch x when the feature is enabled.
  - Same edge: clear the accumulator, set counter=W-1, go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: if multiplier LSB=1, acc += multiplicand (2*W wide, cannot overflow). Then multiplicand <<= 1, multiplier >>= 1, counter -= 1.
  - On the edge where counter==0 (after that edge's add/shift): go to DONE.
  - Exactly W CALC edges per operation.
- DONE:
  - out_valid=1; sq=acc, held stable while out_valid=1.
  - On an edge with out_ready=1: go to IDLE; out_valid drops next cycle.
  - sq keeps its last value after handoff.
- Latency:
  - out_valid rises W edges after the accept edge (11 cycles at default).
  - Throughput: one result per W+2 cycles with out_ready tied high.
- Handshake rules:
  - in_ready depends only on state, never on in_valid.
  - in_valid and r are ignored outside IDLE.
  - out_valid never drops without out_ready.
  - No bypass: a new operand cannot be accepted on the same edge a result is consumed.
- Boundary cases:
  - r=0 gives sq=0, still after W cycles (no early exit).
  - r=2^W-1 gives the maximum result (2^W-1)^2.
  - rst asserted in CALC or DONE aborts the operation with no result emitted; IDLE on the next cycle.
  - in_valid held high across DONE is not consumed until IDLE.

Optional Feature:
- Macro: SQR_RANGE_CHECK_EN.
- Defined:
  - Port x is added and latched at accept.
  - In DONE, ok = (sq <= x) && (x < sq + 2*r_latched + 1), using a 2*W+1-bit compare.
  - ok is valid only while out_valid=1 and is 0 otherwise.
  - This is the hardware check that a sqrt result is the floor root.
- Undefined:
  - Ports x and ok are absent; no comparator logic.
  - Timing otherwise identical.

Decomposition:
- Package isqr_pkg:
  - Default root width constant ISQR_W=11 and derived ISQR_SQW=22.
  - State enum type (IDLE/CALC/DONE) with 2-bit encoding.
- Sub-module:
  - With the feature enabled, the range comparator is a natural sub-module, isqr_range_cmp (inputs sq, r, x; output ok), purely combinational.
  - Without the feature, isqr_seq is a single module.

Test Plan:
- Reset then r=0, in_valid pulse: out_valid rises exactly 11 cycles after accept, sq=0; in_ready=0 throughout.
- r=1448: sq=2096704. r=2047: sq=4190209. Exhaustive sweep r=0..2047 compared against r*r.
- Back-pressure: r=37 with out_ready=0 for 6 cycles after DONE. sq=1369 held, out_valid=1, in_ready=0, and a second in_valid is ignored until the handshake completes.
- Reset mid-CALC: accept r=1000, assert rst at cycle 5. Outputs return to reset values asynchronously, and no out_valid appears. Next operand r=3 gives sq=9.
- Back-to-back with out_ready=1 and in_valid held high: r=5 then r=6 give sq=25 then 36, with 13 cycles between accept edges.
- SQR_RANGE_CHECK_EN:
  - r=1448, x=2096704 gives ok=1.
  - x=2096703 gives ok=0.
  - x=2099600 gives ok=1.
  - x=2099601 gives ok=0.
